// File: rtl/ddr_input_gearbox.sv
// Multi-lane DDR input gearbox.
// Collects one rising/falling bit pair per lane per fabric clock, emits a
// RATIO-bit word per lane every RATIO/2 cycles, and aligns each lane with a
// per-lane bit-slip that is driven by hand or by a training-pattern FSM.
module ddr_input_gearbox #(
  parameter int unsigned      WIDTH         = 16,
  parameter int unsigned      RATIO         = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN = 8'h5C,
  parameter int unsigned      MATCH_COUNT   = 4,
  parameter int unsigned      SLIP_BITS     = (RATIO > 2) ? $clog2(RATIO) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din0,
  input  logic [WIDTH-1:0]           din1,
  input  logic [WIDTH-1:0]           bitslip,
  input  logic                       train_start,
  output logic [WIDTH*RATIO-1:0]     dout,
  output logic                       dout_valid,
  output logic [WIDTH*SLIP_BITS-1:0] lane_slip,
  output logic [WIDTH-1:0]           lane_locked,
  output logic [WIDTH-1:0]           lane_fail,
  output logic                       train_busy,
  output logic                       train_done,
  output logic                       train_ok
);

  localparam int unsigned HALF    = RATIO / 2;
  localparam int unsigned PH_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int unsigned ATT_W   = $clog2(2 * RATIO + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [PH_W-1:0]      r_ph;
  logic                 w_strobe;

  // Only the older 2*RATIO-2 history bits are stored; the incoming pair
  // completes the 2*RATIO-bit window combinationally.
  logic [2*RATIO-3:0]   r_sr      [WIDTH];
  logic [2*RATIO-1:0]   w_sr_next [WIDTH];

  logic [RATIO-1:0]     r_dout    [WIDTH];
  logic                 r_dout_valid;
  logic [SLIP_BITS-1:0] r_slip    [WIDTH];

  logic [MATCH_W-1:0]   r_match      [WIDTH];
  logic [MATCH_W-1:0]   w_match_next [WIDTH];
  logic [ATT_W-1:0]     r_att        [WIDTH];
  logic [ATT_W-1:0]     w_att_next   [WIDTH];

  logic [WIDTH-1:0]     r_skip;
  logic [WIDTH-1:0]     r_locked;
  logic [WIDTH-1:0]     r_fail;
  logic [WIDTH-1:0]     w_skip_next;
  logic [WIDTH-1:0]     w_lock_next;
  logic [WIDTH-1:0]     w_fail_next;
  logic [WIDTH-1:0]     w_train_slip;
  logic [WIDTH-1:0]     w_man_slip;
  logic [WIDTH-1:0]     w_slip_inc;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_ok;

  assign w_strobe   = (r_ph == PH_W'(HALF - 1));
  assign w_man_slip = (r_state == ST_TRAIN) ? '0 : bitslip;
  assign w_slip_inc = w_train_slip | w_man_slip;

  // Free-running word phase; wraps every RATIO/2 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ph <= '0;
    end else if (w_strobe) begin
      r_ph <= '0;
    end else begin
      r_ph <= r_ph + PH_W'(1);
    end
  end

  // Append this cycle's pair below the stored history; din1 is the newest bit.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_sr_next[i] = {r_sr[i], din0[i], din1[i]};
    end
  end

  // History shift, word capture with the pre-slip offset, and slip update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_sr[i]   <= '0;
        r_dout[i] <= '0;
        r_slip[i] <= '0;
      end
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_strobe;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_sr[i] <= w_sr_next[i][2*RATIO-3:0];
        if (w_strobe) begin
          r_dout[i] <= w_sr_next[i][r_slip[i] +: RATIO];
        end
        if (w_slip_inc[i]) begin
          r_slip[i] <= (r_slip[i] == SLIP_BITS'(RATIO - 1)) ? '0
                                                            : r_slip[i] + SLIP_BITS'(1);
        end
      end
    end
  end

  // Per-lane training decision on each presented word while in TRAIN.
  always_comb begin
    w_lock_next  = r_locked;
    w_fail_next  = r_fail;
    w_skip_next  = r_skip;
    w_train_slip = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_match_next[i] = r_match[i];
      w_att_next[i]   = r_att[i];
      if (r_state == ST_TRAIN && r_dout_valid && !r_locked[i] && !r_fail[i]) begin
        if (r_skip[i]) begin
          w_skip_next[i] = 1'b0;
        end else if (r_dout[i] == TRAIN_PATTERN) begin
          w_match_next[i] = r_match[i] + MATCH_W'(1);
          if (r_match[i] == MATCH_W'(MATCH_COUNT - 1)) begin
            w_lock_next[i] = 1'b1;
          end
        end else begin
          w_match_next[i] = '0;
          w_att_next[i]   = r_att[i] + ATT_W'(1);
          w_skip_next[i]  = 1'b1;
          w_train_slip[i] = 1'b1;
          if (r_att[i] == ATT_W'(2 * RATIO - 1)) begin
            w_fail_next[i] = 1'b1;
          end
        end
      end
    end
  end

  // Training FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_locked <= '0;
      r_fail   <= '0;
      r_skip   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_match[i] <= '0;
        r_att[i]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_TRAIN: begin
          r_locked <= w_lock_next;
          r_fail   <= w_fail_next;
          r_skip   <= w_skip_next;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            r_match[i] <= w_match_next[i];
            r_att[i]   <= w_att_next[i];
          end
          if (&(w_lock_next | w_fail_next)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ok    <= &w_lock_next;
          end
        end
        default: begin
          if (train_start) begin
            r_state  <= ST_TRAIN;
            r_busy   <= 1'b1;
            r_locked <= '0;
            r_fail   <= '0;
            r_skip   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
              r_match[i] <= '0;
              r_att[i]   <= '0;
            end
          end else begin
            r_locked <= r_locked & ~bitslip;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_out
    assign dout[g*RATIO +: RATIO]              = r_dout[g];
    assign lane_slip[g*SLIP_BITS +: SLIP_BITS] = r_slip[g];
  end

  assign dout_valid  = r_dout_valid;
  assign lane_locked = r_locked;
  assign lane_fail   = r_fail;
  assign train_busy  = r_busy;
  assign train_done  = r_done;
  assign train_ok    = r_ok;

endmodule

// File: tb/tb_ddr_input_gearbox.sv
// Bench for ddr_input_gearbox: a bit-stream level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ddr_input_gearbox;

  localparam int W    = 16;
  localparam int R    = 8;
  localparam int SB   = 3;
  localparam int MC   = 4;
  localparam int MAXB = 4096;
  localparam logic [7:0] PAT = 8'h5C;

  typedef logic [W*R-1:0] vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din0 = '0;
  logic [W-1:0]   din1 = '0;
  logic [W-1:0]   bitslip = '0;
  logic           train_start = 1'b0;
  logic [W*R-1:0] dout;
  logic           dout_valid;
  logic [W*SB-1:0] lane_slip;
  logic [W-1:0]   lane_locked;
  logic [W-1:0]   lane_fail;
  logic           train_busy;
  logic           train_done;
  logic           train_ok;

  always #5 clk = ~clk;

  ddr_input_gearbox #(
    .WIDTH(W), .RATIO(R), .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC), .SLIP_BITS(SB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din0(din0), .din1(din1), .bitslip(bitslip),
    .train_start(train_start), .dout(dout), .dout_valid(dout_valid),
    .lane_slip(lane_slip), .lane_locked(lane_locked), .lane_fail(lane_fail),
    .train_busy(train_busy), .train_done(train_done), .train_ok(train_ok)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus: each lane sends a repeating word MSB-first, shifted by lane_off.
  logic [7:0] lane_pat [W];
  int         lane_off [W];
  logic [W-1:0] lane_zero = '0;
  int         gpos = 0;
  logic       rst_v = 1'b0;
  int         soff [W] = '{0, 1, 2, 5, 3, 4, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};

  function automatic logic gen_bit(input int i, input int p);
    logic [7:0] w;
    if (lane_zero[i]) return 1'b0;
    w = lane_pat[i];
    return w[R - 1 - ((p + lane_off[i]) % R)];
  endfunction

  task automatic step(input logic [W-1:0] bs, input logic ts);
    @(negedge clk);
    if (rst_v) begin
      for (int i = 0; i < W; i++) begin
        din0[i] = gen_bit(i, gpos);
        din1[i] = gen_bit(i, gpos + 1);
      end
      gpos += 2;
    end else begin
      din0 = W'($urandom);
      din1 = W'($urandom);
      gpos = 0;
    end
    rst_n       = rst_v;
    bitslip     = bs;
    train_start = ts;
    @(posedge clk);
    #2;
  endtask

  // Reference model: keeps the received bit stream per lane and derives words
  // from stream positions; training follows the word-level rules.
  int           m_st = 0;
  int           m_cyc = 0;
  int           m_n = 0;
  int           m_slip  [W];
  int           m_match [W];
  int           m_att   [W];
  bit           m_skip  [W];
  logic [W-1:0] m_lock = '0;
  logic [W-1:0] m_fail = '0;
  logic [7:0]   e_dout  [W];
  logic         e_valid = 1'b0;
  logic         e_busy = 1'b0;
  logic         e_done = 1'b0;
  logic         e_ok = 1'b0;
  bit           m_bits  [W][MAXB];
  bit           m_live = 1'b0;

  function automatic logic [7:0] m_word(input int i, input int s);
    logic [7:0] w;
    int idx;
    for (int k = 0; k < R; k++) begin
      idx  = m_n - 1 - s - k;
      w[k] = (idx >= 0) ? m_bits[i][idx] : 1'b0;
    end
    return w;
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0]    lk, fl, inc;
    logic [W*R-1:0]  ed;
    logic [W*SB-1:0] es;
    if (!rst_n) begin
      m_live = 1'b1;
      m_st = 0; m_cyc = 0; m_n = 0;
      m_lock = '0; m_fail = '0;
      e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ok = 1'b0;
      for (int i = 0; i < W; i++) begin
        m_slip[i] = 0; m_match[i] = 0; m_att[i] = 0; m_skip[i] = 1'b0;
        e_dout[i] = '0;
      end
    end else begin
      lk = m_lock; fl = m_fail; inc = '0; e_done = 1'b0;
      if (m_st == 1) begin
        if (e_valid) begin
          for (int i = 0; i < W; i++) begin
            if (!lk[i] && !fl[i]) begin
              if (m_skip[i]) begin
                m_skip[i] = 1'b0;
              end else if (e_dout[i] == PAT) begin
                m_match[i]++;
                if (m_match[i] == MC) lk[i] = 1'b1;
              end else begin
                m_match[i] = 0;
                m_att[i]++;
                m_skip[i] = 1'b1;
                inc[i] = 1'b1;
                if (m_att[i] == 2 * R) fl[i] = 1'b1;
              end
            end
          end
        end
        if (&(lk | fl)) begin
          m_st = 2; e_busy = 1'b0; e_done = 1'b1; e_ok = &lk;
        end
      end else begin
        for (int i = 0; i < W; i++) begin
          if (bitslip[i]) begin
            inc[i] = 1'b1;
            lk[i]  = 1'b0;
          end
        end
        if (train_start) begin
          m_st = 1; e_busy = 1'b1; lk = '0; fl = '0;
          for (int i = 0; i < W; i++) begin
            m_match[i] = 0; m_att[i] = 0; m_skip[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < W; i++) begin
        m_bits[i][m_n]     = din0[i];
        m_bits[i][m_n + 1] = din1[i];
      end
      m_n += 2;
      if (m_cyc % (R / 2) == R / 2 - 1) begin
        for (int i = 0; i < W; i++) e_dout[i] = m_word(i, m_slip[i]);
        e_valid = 1'b1;
      end else begin
        e_valid = 1'b0;
      end
      m_cyc++;
      for (int i = 0; i < W; i++) begin
        if (inc[i]) m_slip[i] = (m_slip[i] + 1) % R;
      end
      m_lock = lk;
      m_fail = fl;
    end
    #1;
    if (m_live) begin
      for (int i = 0; i < W; i++) begin
        ed[i*R +: R]   = e_dout[i];
        es[i*SB +: SB] = SB'(m_slip[i]);
      end
      chk("m_valid",  vec_t'(dout_valid),  vec_t'(e_valid));
      chk("m_dout",   vec_t'(dout),        vec_t'(ed));
      chk("m_slip",   vec_t'(lane_slip),   vec_t'(es));
      chk("m_locked", vec_t'(lane_locked), vec_t'(m_lock));
      chk("m_fail",   vec_t'(lane_fail),   vec_t'(m_fail));
      chk("m_busy",   vec_t'(train_busy),  vec_t'(e_busy));
      chk("m_done",   vec_t'(train_done),  vec_t'(e_done));
      chk("m_ok",     vec_t'(train_ok),    vec_t'(e_ok));
    end
  end

  task automatic do_reset();
    rst_v = 1'b0;
    step('0, 1'b0);
    step('0, 1'b0);
    rst_v = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 1; k <= 16 && n < 0; k++) begin
      step('0, 1'b0);
      if (dout_valid) n = k;
    end
  endtask

  int t_words, t_done_cnt;
  int t_slips [W];

  task automatic run_train(input logic [W-1:0] bs_first);
    logic [W*SB-1:0] prev;
    bit fin;
    prev = lane_slip;
    t_words = 0; t_done_cnt = 0; fin = 1'b0;
    for (int i = 0; i < W; i++) t_slips[i] = 0;
    for (int k = 0; k < 600 && !fin; k++) begin
      if (k == 0)      step('0, 1'b1);
      else if (k == 1) step(bs_first, 1'b0);
      else             step('0, 1'b0);
      if (dout_valid && train_busy) t_words++;
      for (int i = 0; i < W; i++) begin
        if (lane_slip[i*SB +: SB] != prev[i*SB +: SB]) t_slips[i]++;
      end
      prev = lane_slip;
      if (train_done) begin
        t_done_cnt++;
        fin = 1'b1;
      end
    end
    chk("train_finished", vec_t'(fin), vec_t'(1));
    repeat (8) begin
      step('0, 1'b0);
      if (train_done) t_done_cnt++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin : main
    int n;
    logic [W*SB-1:0] exp_slip;
    for (int i = 0; i < W; i++) begin
      lane_pat[i] = PAT;
      lane_off[i] = 0;
    end
    lane_pat[0] = 8'hA5;

    // Reset with random inputs.
    rst_v = 1'b0;
    repeat (3) step('0, 1'b0);
    chk("rst_dout",   vec_t'(dout),        '0);
    chk("rst_valid",  vec_t'(dout_valid),  '0);
    chk("rst_slip",   vec_t'(lane_slip),   '0);
    chk("rst_locked", vec_t'(lane_locked), '0);
    chk("rst_fail",   vec_t'(lane_fail),   '0);
    chk("rst_busy",   vec_t'(train_busy),  '0);
    chk("rst_done",   vec_t'(train_done),  '0);
    chk("rst_ok",     vec_t'(train_ok),    '0);

    // Strobe timing and pass-through.
    rst_v = 1'b1;
    wait_valid(n);
    chk("first_valid_latency", vec_t'(n), vec_t'(4));
    chk("pass_a5_w1", vec_t'(dout[7:0]), vec_t'(8'hA5));
    chk("pass_lane1", vec_t'(dout[15:8]), vec_t'(8'h5C));
    wait_valid(n);
    chk("valid_period", vec_t'(n), vec_t'(4));
    chk("pass_a5_w2", vec_t'(dout[7:0]), vec_t'(8'hA5));
    step(16'h0001, 1'b0);
    chk("manual_slip0", vec_t'(lane_slip[2:0]), vec_t'(3'd1));
    wait_valid(n);
    chk("slip_word1", vec_t'(dout[7:0]), vec_t'(8'hD2));
    wait_valid(n);
    chk("slip_word2", vec_t'(dout[7:0]), vec_t'(8'hD2));

    // Aligned training; a bitslip during TRAIN must be ignored.
    lane_pat[0] = PAT;
    do_reset();
    repeat (8) step('0, 1'b0);
    run_train('1);
    chk("aligned_words",  vec_t'(t_words),     vec_t'(MC));
    chk("aligned_done",   vec_t'(t_done_cnt),  vec_t'(1));
    chk("aligned_ok",     vec_t'(train_ok),    vec_t'(1));
    chk("aligned_locked", vec_t'(lane_locked), vec_t'(16'hFFFF));
    chk("aligned_slip",   vec_t'(lane_slip),   '0);

    // Training with per-lane offsets.
    for (int i = 0; i < W; i++) lane_off[i] = soff[i];
    do_reset();
    repeat (8) step('0, 1'b0);
    run_train('0);
    for (int i = 0; i < W; i++) exp_slip[i*SB +: SB] = SB'(soff[i]);
    chk("offs_done",   vec_t'(t_done_cnt),  vec_t'(1));
    chk("offs_ok",     vec_t'(train_ok),    vec_t'(1));
    chk("offs_locked", vec_t'(lane_locked), vec_t'(16'hFFFF));
    chk("offs_slip",   vec_t'(lane_slip),   vec_t'(exp_slip));
    for (int i = 0; i < W; i++) chk($sformatf("offs_nslips_%0d", i), vec_t'(t_slips[i]), vec_t'(soff[i]));
    wait_valid(n);
    for (int i = 0; i < W; i++) chk($sformatf("offs_word_%0d", i), vec_t'(dout[i*R +: R]), vec_t'(PAT));

    // Restart from DONE, then manual slip in DONE clears that lane's lock.
    run_train('0);
    chk("restart_words", vec_t'(t_words),    vec_t'(MC));
    chk("restart_done",  vec_t'(t_done_cnt), vec_t'(1));
    chk("restart_slip",  vec_t'(lane_slip),  vec_t'(exp_slip));
    chk("restart_ok",    vec_t'(train_ok),   vec_t'(1));
    step(16'h0020, 1'b0);
    chk("done_bitslip_locked", vec_t'(lane_locked), vec_t'(16'hFFDF));
    chk("done_bitslip_slip5",  vec_t'(lane_slip[5*SB +: SB]), vec_t'(3'd5));

    // Lane 2 stuck at zero must fail after 2*RATIO slips.
    for (int i = 0; i < W; i++) lane_off[i] = 0;
    lane_zero = 16'h0004;
    do_reset();
    repeat (8) step('0, 1'b0);
    run_train('0);
    chk("fail_flags",  vec_t'(lane_fail),   vec_t'(16'h0004));
    chk("fail_locked", vec_t'(lane_locked), vec_t'(16'hFFFB));
    chk("fail_ok",     vec_t'(train_ok),    vec_t'(0));
    chk("fail_done",   vec_t'(t_done_cnt),  vec_t'(1));
    chk("fail_nslips", vec_t'(t_slips[2]),  vec_t'(16));
    chk("fail_slip2",  vec_t'(lane_slip[2*SB +: SB]), vec_t'(3'd0));

    // Reset in the middle of training.
    lane_zero = '0;
    for (int i = 0; i < W; i++) lane_off[i] = soff[i];
    do_reset();
    repeat (8) step('0, 1'b0);
    step('0, 1'b1);
    repeat (12) step('0, 1'b0);
    chk("mid_busy_before", vec_t'(train_busy), vec_t'(1));
    rst_v = 1'b0;
    step('0, 1'b0);
    chk("mid_rst_busy",   vec_t'(train_busy),  '0);
    chk("mid_rst_locked", vec_t'(lane_locked), '0);
    chk("mid_rst_fail",   vec_t'(lane_fail),   '0);
    chk("mid_rst_slip",   vec_t'(lane_slip),   '0);
    chk("mid_rst_dout",   vec_t'(dout),        '0);
    rst_v = 1'b1;
    repeat (6) step('0, 1'b0);
    chk("post_rst_idle", vec_t'(train_busy), '0);
    chk("post_rst_slip", vec_t'(lane_slip),  '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_input_gearbox.md
Name: ddr_input_gearbox

Overview:
- Parametrised multi-lane DDR deserializer stage that sits directly behind the per-pin DDR input buffers.
- Accepts per-lane rising/falling bit pairs already in the fabric clock domain and assembles them into RATIO-bit words per lane.
- Provides per-lane bit-slip alignment, both manual and automatic, using a training-pattern FSM that reports per-lane lock and fail status.

Parameters:
- WIDTH, 16, number of lanes.
- RATIO, 8, bits per lane per output word; even, 2..16.
- TRAIN_PATTERN, 8'h5C, RATIO-bit aperiodic training word (no rotation equals itself).
- MATCH_COUNT, 4, consecutive matching words required to declare a lane locked.
- SLIP_BITS, $clog2(RATIO) (minimum 1), width of each per-lane slip field.

Ports:
- clk  in  1  fabric clock; DDR pairs arrive once per cycle.
- rst_n  in  1  synchronous active-low reset.
- din0  in  WIDTH  first-in-time bit per lane (rising-edge sample).
- din1  in  WIDTH  second-in-time bit per lane (falling-edge sample).
- bitslip  in  WIDTH  manual slip request, one-cycle pulse per lane.
- train_start  in  1  pulse: begin auto-training.
- dout  out  WIDTH*RATIO  lane i at [i*RATIO +: RATIO]; MSB is the oldest bit.
- dout_valid  out  1  one-cycle strobe per word.
- lane_slip  out  WIDTH*SLIP_BITS  current slip per lane.
- lane_locked  out  WIDTH  per-lane lock flag.
- lane_fail  out  WIDTH  per-lane training failure flag.
- train_busy  out  1  high while in TRAIN.
- train_done  out  1  one-cycle pulse on TRAIN->DONE.
- train_ok  out  1  level; all lanes locked at the last completion.

Behaviour:
- Reset (rst_n low at a clk edge): every output is 0, all history registers are 0, phase is 0, FSM is IDLE. This applies mid-training too; no partial state survives.
- Per-lane history: sr is 2*RATIO bits. Each cycle, sr <= {sr[2R-3:0], din0[i], din1[i]}, so din1 is the newest bit at the LSB.
- Phase counter: ph counts 0..RATIO/2-1 and wraps; it is free-running after reset.
  - On the edge where ph==RATIO/2-1: dout lane i <= sr_next[i][slip_i +: RATIO] and dout_valid <= 1.
  - On all other edges dout_valid <= 0 and dout holds its value.
  - RATIO=2: dout_valid is high every cycle.
- Latency: bit pair to dout is at most RATIO/2 cycles; it is exactly 1 cycle for the newest pair in a word.
- slip_i: larger values select older bits. Each slip advances slip_i by 1, wrapping from RATIO-1 to 0.
- Manual slip: bitslip[i] is honoured only in IDLE or DONE, and applies at the next edge. A manual slip clears lane_locked[i]. bitslip is ignored during TRAIN.
- FSM states:
  - IDLE: on train_start, go to TRAIN. Clear lane_locked, lane_fail, match counters, slip-attempt counters and skip flags. slip values are retained.
  - TRAIN: train_busy=1. On each dout_valid, for every lane not locked and not failed:
    - If skip_i is set: clear skip_i and do not compare.
    - Else if word==TRAIN_PATTERN: match_i++. When match_i reaches MATCH_COUNT, set lane_locked[i].
    - Else: match_i=0, slip_i++, attempts_i++, set skip_i. The next word still reflects the old slip when RATIO=2, so exactly one word is always discarded after a slip.
    - When attempts_i reaches 2*RATIO, set lane_fail[i].
    - When every lane is locked or failed: go to DONE, pulse train_done, and set train_ok = &lane_locked.
  - DONE: train_busy=0, status flags hold. train_start restarts training exactly as from IDLE.
- train_start during TRAIN is ignored.
- A slip and a word strobe on the same edge: the captured word uses the pre-slip value.
- A locked lane is frozen: no further comparisons and no slips until the next train_start.
- Counter widths: match counter is $clog2(MATCH_COUNT+1) bits; attempts counter is $clog2(2*RATIO+1) bits; neither counter overflows.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random din -> all outputs 0. Release -> first dout_valid exactly RATIO/2 cycles later; thereafter the strobe period is RATIO/2 cycles.
- Pass-through, RATIO=8: drive lane 0 with serial 0xA5 repeating, phase-aligned to slip 0 -> every dout lane0 word == 8'hA5. Issue bitslip[0] once -> lane_slip0=1 and subsequent words are the 1-bit rotation of 0xA5.
- Auto-train, aligned: all lanes send 0x5C aligned, then pulse train_start -> no slips, all lane_locked after exactly MATCH_COUNT words, train_done pulses once, train_ok=1, lane_slip all 0.
- Auto-train, offsets: each lane i uses a bench-chosen offset s_i in 0..7 (e.g. lane 3 s=5) -> per lane exactly s_i slips, lane_slip==s_i, train_ok=1, locked lanes' dout == 0x5C.
- Failure: lane 2 driven with constant 0 -> lane_fail[2] after 16 slips; other lanes locked; train_done pulses; train_ok=0.
- Reset mid-training: assert rst_n=0 during TRAIN -> state IDLE, flags 0, slips 0. Manual bitslip asserted during TRAIN -> no slip change.
